// File: rtl/mem_access_unit_pkg.sv
// Shared types and sizing for the memory access unit: MAR/MDR widths,
// the transaction FSM encoding and the wait-state timeout.
package mem_access_unit_pkg;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU datapath/memory side (master) and the
// memory access unit (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              Read;
  logic              Write;
  logic              MemAck;
  logic [DATA_W-1:0] MemDataIn;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemDataOut;
  logic              MemReq;
  logic              MemWe;
  logic [DATA_W-1:0] BusMuxInMDR;
  logic              MemBusy;
  logic              MemDone;
  logic              MemErr;

  modport master (
    output BusMuxOut, MARin, MDRin, Read, Write, MemAck, MemDataIn,
    input  MemAddr, MemDataOut, MemReq, MemWe, BusMuxInMDR, MemBusy, MemDone, MemErr
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read, Write, MemAck, MemDataIn,
    output MemAddr, MemDataOut, MemReq, MemWe, BusMuxInMDR, MemBusy, MemDone, MemErr
  );

endinterface

// File: rtl/mem_access_unit_register32.sv
// Generic register with synchronous clear and load enable; 32 bits by
// default, narrowed for the MAR.
module register32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb q_d = load ? d : q_q;

  // NOTE: non-blocking assignment in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers plus a read/write handshake FSM
// with a bounded wait for MemAck and a sticky timeout flag.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mar_load, mdr_load;
  logic [DATA_W-1:0] mdr_in, mdr_q;
  logic [ADDR_W-1:0] mar_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mar_load = 1'b0;
    mdr_load = 1'b0;
    mdr_in   = bus.BusMuxOut;
    unique case (state_q)
      ST_IDLE: begin
        // Register loads share the edge with command acceptance, so the
        // request sees the freshly loaded MAR/MDR.
        mar_load = bus.MARin;
        mdr_load = bus.MDRin;
        cnt_d    = '0;
        if (bus.Read) begin
          state_d = ST_READ;
          err_d   = 1'b0;
        end else if (bus.Write) begin
          state_d = ST_WRITE;
          err_d   = 1'b0;
        end
      end
      ST_READ, ST_WRITE: begin
        if (bus.MemAck) begin
          state_d = ST_DONE;
          if (state_q == ST_READ) begin
            mdr_load = 1'b1;
            mdr_in   = bus.MemDataIn;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  register32 #(.WIDTH(ADDR_W)) u_mar (
    .clock (clock),
    .clear (clear),
    .load  (mar_load),
    .d     (bus.BusMuxOut[ADDR_W-1:0]),
    .q     (mar_q)
  );

  register32 #(.WIDTH(DATA_W)) u_mdr (
    .clock (clock),
    .clear (clear),
    .load  (mdr_load),
    .d     (mdr_in),
    .q     (mdr_q)
  );

  assign bus.MemAddr     = mar_q;
  assign bus.MemDataOut  = mdr_q;
  assign bus.BusMuxInMDR = mdr_q;
  assign bus.MemReq      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign bus.MemBusy     = bus.MemReq;
  assign bus.MemWe       = (state_q == ST_WRITE);
  assign bus.MemDone     = (state_q == ST_DONE);
  assign bus.MemErr      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized transactions against a transaction-level model
// of MAR, MDR and the error flag.
module tb_mem_access_unit;

  logic clock = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  logic        m_err;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_quiet();
    bus.BusMuxOut = '0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.MemAck    = 1'b0;
    bus.MemDataIn = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " MemAddr"},     {23'd0, bus.MemAddr}, {23'd0, m_mar});
    check({tag, " MemDataOut"},  bus.MemDataOut,  m_mdr);
    check({tag, " BusMuxInMDR"}, bus.BusMuxInMDR, m_mdr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " MemReq"},  {31'd0, bus.MemReq},  32'd0);
    check({tag, " MemBusy"}, {31'd0, bus.MemBusy}, 32'd0);
    check({tag, " MemDone"}, {31'd0, bus.MemDone}, 32'd0);
    check({tag, " MemErr"},  {31'd0, bus.MemErr},  {31'd0, m_err});
    check_regs(tag);
  endtask

  task automatic load_regs(input logic ml, input logic dl, input logic [31:0] v);
    bus.MARin = ml;
    bus.MDRin = dl;
    bus.BusMuxOut = v;
    if (ml) m_mar = v[8:0];
    if (dl) m_mdr = v;
    tick();
    drive_quiet();
    check_idle("load");
  endtask

  // ack_cycle: request cycle (1..16) carrying MemAck, 0 for no ack at all.
  task automatic do_cmd(input string tag, input logic rd, input logic wr,
                        input logic ml, input logic dl, input logic [31:0] v,
                        input int ack_cycle, input logic [31:0] rdata,
                        input logic noise, input logic [31:0] noise_bus);
    logic is_read;
    logic acked;
    is_read = rd;
    acked   = 1'b0;
    bus.Read      = rd;
    bus.Write     = wr;
    bus.MARin     = ml;
    bus.MDRin     = dl;
    bus.BusMuxOut = v;
    bus.MemAck    = 1'($urandom_range(0, 1));
    if (ml) m_mar = v[8:0];
    if (dl) m_mdr = v;
    m_err = 1'b0;
    tick();
    drive_quiet();
    for (int k = 1; k <= 16; k++) begin
      check({tag, " req MemReq"},  {31'd0, bus.MemReq},  32'd1);
      check({tag, " req MemBusy"}, {31'd0, bus.MemBusy}, 32'd1);
      check({tag, " req MemWe"},   {31'd0, bus.MemWe},   {31'd0, !is_read});
      check({tag, " req MemDone"}, {31'd0, bus.MemDone}, 32'd0);
      check({tag, " req MemErr"},  {31'd0, bus.MemErr},  32'd0);
      check_regs({tag, " req"});
      bus.MARin     = noise;
      bus.MDRin     = noise;
      bus.BusMuxOut = noise_bus;
      bus.MemAck    = (k == ack_cycle);
      bus.MemDataIn = (k == ack_cycle) ? rdata : $urandom;
      tick();
      if (k == ack_cycle) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      if (is_read) m_mdr = rdata;
      check({tag, " done MemDone"}, {31'd0, bus.MemDone}, 32'd1);
      check({tag, " done MemReq"},  {31'd0, bus.MemReq},  32'd0);
      check({tag, " done MemErr"},  {31'd0, bus.MemErr},  32'd0);
      check_regs({tag, " done"});
      // Commands, loads and acks during DONE must all be ignored.
      bus.Read   = 1'b1;
      bus.Write  = 1'($urandom_range(0, 1));
      bus.MemAck = 1'b1;
      tick();
      drive_quiet();
      check_idle({tag, " after done"});
    end else begin
      drive_quiet();
      m_err = 1'b1;
      check_idle({tag, " timeout"});
      tick();
      check_idle({tag, " timeout+1"});
    end
  endtask

  initial begin
    drive_quiet();
    clear = 1'b1;
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    check_idle("reset");
    check({"reset MemWe"}, {31'd0, bus.MemWe}, 32'd0);

    // Read of address 5 with minimum-latency ack.
    load_regs(1'b1, 1'b0, 32'h0000_0005);
    do_cmd("read", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check("read MDR", bus.BusMuxInMDR, 32'hDEAD_BEEF);

    // Write with same-cycle MDR load, ack three cycles after MemReq rises.
    do_cmd("write", 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 4, 32'h0, 1'b0, 32'h0);
    check("write MDR", bus.MemDataOut, 32'h1234_5678);

    // Timeout, then a write must clear the sticky error.
    do_cmd("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 32'h0);
    check("timeout MemErr", {31'd0, bus.MemErr}, 32'd1);
    do_cmd("after_to", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2, 32'h0, 1'b0, 32'h0);

    // Busy guard: loads attempted throughout a read are ignored.
    do_cmd("guard", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0033, 3, 32'hCAFE_F00D, 1'b1, 32'hFFFF_FFFF);

    // Priority: Read+Write together behaves as a read.
    do_cmd("prio", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2, 32'h0BAD_CAFE, 1'b0, 32'h0);

    // Boundary: ack in the 16th wait cycle is a success.
    do_cmd("ack16", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_01A5, 16, 32'h5A5A_A5A5, 1'b0, 32'h0);

    // Reset in the second WRITE cycle aborts with no completion.
    load_regs(1'b1, 1'b1, 32'h0000_00AB);
    bus.Write = 1'b1;
    tick();
    drive_quiet();
    check("abort req1 MemReq", {31'd0, bus.MemReq}, 32'd1);
    tick();
    check("abort req2 MemWe", {31'd0, bus.MemWe}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
    check_idle("abort");
    bus.MemAck    = 1'b1;
    bus.MemDataIn = 32'hFFFF_0000;
    tick();
    drive_quiet();
    check_idle("late ack");

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      logic rd, wr, ml, dl, nz;
      int   ac;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) wr = 1'b1;
      ml = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      nz = 1'($urandom_range(0, 1));
      ac = $urandom_range(0, 16);
      do_cmd("rand", rd, wr, ml, dl, $urandom, ac, $urandom, nz, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with clock and clear as the first two ports.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 clear  in  1  synchronous active-high reset.
REQ-004 BusMuxOut  in  32  current bus value.
REQ-005 MARin  in  1  load MAR from BusMuxOut[8:0].
REQ-006 MDRin  in  1  load MDR from BusMuxOut.
REQ-007 Read  in  1  start memory read of [MAR] into MDR.
REQ-008 Write  in  1  start memory write of MDR to [MAR].
REQ-009 MemAck  in  1  memory completion strobe.
REQ-010 MemDataIn  in  32  memory read data, valid with MemAck.
REQ-011 MemAddr  out  9  MAR contents.
REQ-012 MemDataOut  out  32  MDR contents.
REQ-013 MemReq  out  1  request active.
REQ-014 MemWe  out  1  write qualifier, meaningful only with MemReq.
REQ-015 BusMuxInMDR  out  32  MDR contents, feeding the bus MDR input.
REQ-016 MemBusy  out  1  high in READ or WRITE.
REQ-017 MemDone  out  1  one-cycle completion pulse.
REQ-018 MemErr  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, WRITE and DONE; all outputs SHALL be registered or decoded from state only.
REQ-020 Transitions from IDLE SHALL be as follows.
- Read=1 -> READ.
- Write=1 with Read=0 -> WRITE.
- Read and Write both high -> READ (Read has priority).
REQ-021 Accepting a command SHALL clear MemErr.
REQ-022 In READ and WRITE, MemReq SHALL be 1, MemBusy SHALL be 1, and MemWe SHALL be 1 only in WRITE.
REQ-023 In READ with MemAck=1, MDR SHALL load MemDataIn at that edge and the FSM SHALL move to DONE.
REQ-024 In WRITE with MemAck=1, the FSM SHALL move to DONE with MDR unchanged.
REQ-025 DONE SHALL last exactly one cycle with MemDone=1, then return to IDLE; commands in DONE SHALL be ignored.
REQ-026 Minimum latency: command at cycle 0, MemReq at cycle 1, MemAck at cycle 1, MemDone and new MDR visible at cycle 2.
REQ-027 A 4-bit wait counter SHALL clear on entry to READ/WRITE and increment each cycle without MemAck.
REQ-028 After the 16th consecutive request cycle without MemAck, the FSM SHALL return to IDLE, set MemErr=1, leave MDR unchanged and not pulse MemDone.
REQ-029 MemAck in that 16th cycle SHALL count as success.
REQ-030 MARin and MDRin SHALL take effect only in IDLE; in all other states they are ignored, keeping MemAddr and MemDataOut stable.
REQ-031 MARin or MDRin in the same IDLE cycle as a command SHALL load first, so the request uses the newly loaded value.
REQ-032 MemAck outside READ/WRITE SHALL be ignored.
REQ-033 MemAddr SHALL equal MAR, and both MemDataOut and BusMuxInMDR SHALL equal MDR, at all times.

Reset
REQ-034 clear=1 at a clock edge SHALL force the following.
- State IDLE.
- MAR=0, MDR=0, counter=0.
- MemReq, MemWe, MemBusy, MemDone and MemErr all 0.
REQ-035 clear SHALL take priority over all other inputs, including mid-transaction; an aborted transaction SHALL produce no MemDone and no MDR update.

Structure
REQ-036 A shared package SHALL hold the state enum, ADDR_W=9, DATA_W=32 and TIMEOUT=16.
REQ-037 MAR and MDR SHALL each instantiate one sub-module, register32: a 32-bit register with synchronous clear and load enable, width-parameterised for MAR.

Verification
REQ-038 Read: MARin with bus=0x0000_0005, then Read; MemAck one cycle after MemReq with MemDataIn=0xDEAD_BEEF -> MemAddr=5, MemWe=0, then one MemDone pulse with BusMuxInMDR=0xDEAD_BEEF.
REQ-039 Write: MDRin and Write in the same cycle with bus=0x1234_5678 -> MemReq=1, MemWe=1, MemDataOut=0x1234_5678; MemAck after 3 cycles -> MemDone one cycle later.
REQ-040 Timeout: Read with MemAck held 0 -> MemReq drops after 16 cycles, MemErr=1, MDR unchanged, no MemDone; next Write clears MemErr.
REQ-041 Busy guard: during READ, MARin with bus=0x1FF and MDRin with bus=0xFFFF_FFFF -> MemAddr and MDR unchanged until IDLE.
REQ-042 Reset mid-op: clear asserted in the 2nd WRITE cycle -> next cycle MemReq=0, MAR=0, MDR=0, no MemDone; a late MemAck is ignored.
REQ-043 Priority and boundary: Read and Write together -> MemWe=0; MemAck in the 16th wait cycle -> MemDone=1 and MemErr=0.
